// File: rtl/lsu_dram_if.sv
// rtl/lsu_dram_if.sv - load/store unit between execute stage and a word-aligned req/ack data bus
// Define MISALIGN_TRAP_EN to trap misaligned accesses instead of forcing natural alignment.
module lsu_dram_if #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] RESET_RD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] dram_rd,
  output logic        done,
  output logic        stall,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);
  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nx;
  logic          we_q, err_q;
  logic [2:0]    f3_q;
  logic [1:0]    lo_q, lo_al;
  logic [CW-1:0] cnt;
  logic          is_b, is_h, trap_mis;
  logic [3:0]    strb;
  logic [31:0]   wdat, ld_val;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;
  logic          accept, trap, take_ack, tmo;

  assign is_b  = (funct3[1:0] == 2'b00);
  assign is_h  = (funct3[1:0] == 2'b01);
  assign stall = mem_req & ~done;

  // Anything that is neither byte nor half (including reserved codes) is a word.
  always_comb begin
    lo_al = 2'b00;
    strb  = 4'b1111;
    wdat  = wdata;
    if (is_b) begin
      lo_al = addr[1:0];
      strb  = 4'b0001 << addr[1:0];
      wdat  = {4{wdata[7:0]}};
    end else if (is_h) begin
      lo_al = {addr[1], 1'b0};
      strb  = 4'b0011 << {addr[1], 1'b0};
      wdat  = {2{wdata[15:0]}};
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign trap_mis = (is_h & addr[0]) | (~is_b & ~is_h & (|addr[1:0]));
`else
  assign trap_mis = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    trap     = 1'b0;
    take_ack = 1'b0;
    tmo      = 1'b0;
    case (state)
      IDLE: begin
        // done still high means mem_req belongs to the access just finished
        if (mem_req && !done) begin
          if (trap_mis) begin
            trap     = 1'b1;
            state_nx = RESP;
          end else begin
            accept   = 1'b1;
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus_ack) begin
          take_ack = 1'b1;
          state_nx = RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          tmo      = 1'b1;
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    case (lo_q)
      2'd0:    ld_b = bus_rdata[7:0];
      2'd1:    ld_b = bus_rdata[15:8];
      2'd2:    ld_b = bus_rdata[23:16];
      default: ld_b = bus_rdata[31:24];
    endcase
    ld_h = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  ld_val = {{24{ld_b[7]}}, ld_b};
      3'b100:  ld_val = {24'h0, ld_b};
      3'b001:  ld_val = {{16{ld_h[15]}}, ld_h};
      3'b101:  ld_val = {16'h0, ld_h};
      default: ld_val = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_wstrb <= 4'h0;
      bus_wdata <= 32'h0;
      done      <= 1'b0;
      bus_err   <= 1'b0;
      dram_rd   <= RESET_RD;
      cnt       <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      f3_q      <= 3'b000;
      lo_q      <= 2'b00;
    end else begin
      done    <= 1'b0;
      bus_err <= 1'b0;
      if (accept) begin
        bus_req   <= 1'b1;
        bus_we    <= mem_we;
        bus_addr  <= {addr[31:2], 2'b00};
        bus_wstrb <= mem_we ? strb : 4'h0;
        bus_wdata <= wdat;
        we_q      <= mem_we;
        f3_q      <= funct3;
        lo_q      <= lo_al;
        cnt       <= '0;
        err_q     <= 1'b0;
      end
      if (trap) err_q <= 1'b1;
      if (state == WAIT) cnt <= cnt + 1'b1;
      if (take_ack) begin
        bus_req <= 1'b0;
        if (!we_q) dram_rd <= ld_val;
      end
      if (tmo) begin
        bus_req <= 1'b0;
        err_q   <= 1'b1;
        dram_rd <= RESET_RD;
      end
      // Error and completion are reported together on the way out of RESP.
      if (state == RESP) begin
        done    <= 1'b1;
        bus_err <= err_q;
      end
    end
  end
endmodule

// File: tb/tb_lsu_dram_if.sv
// tb/tb_lsu_dram_if.sv - self-checking bench for lsu_dram_if (honours MISALIGN_TRAP_EN)
module tb_lsu_dram_if;
  localparam int TIMEOUT = 16;
  localparam logic [31:0] RESET_RD = 32'h0000_0000;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, mem_req, mem_we, bus_ack;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, bus_rdata;
  logic [31:0] dram_rd, bus_addr, bus_wdata;
  logic        done, stall, bus_err, bus_req, bus_we;
  logic [3:0]  bus_wstrb;

  always #5 clk = ~clk;

  lsu_dram_if #(.TIMEOUT(TIMEOUT), .RESET_RD(RESET_RD)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .dram_rd(dram_rd), .done(done), .stall(stall),
    .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a, wd, rdat;
    int          dly;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata, e_rd;
    logic        mis;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a, wd, rdat,
                              input int dly, input logic [31:0] e_addr, input logic [3:0] e_strb,
                              input logic [31:0] e_wdata, e_rd, input logic mis);
    vec_t v;
    v.we = we; v.f3 = f3; v.a = a; v.wd = wd; v.rdat = rdat; v.dly = dly;
    v.e_addr = e_addr; v.e_strb = e_strb; v.e_wdata = e_wdata; v.e_rd = e_rd; v.mis = mis;
    return v;
  endfunction

  // Reference: access size in bytes, naturally aligned offset, masks built arithmetically.
  function automatic vec_t model(input logic we, input logic [2:0] f3, input logic [31:0] a, wd, rdat,
                                 input int dly, input logic [31:0] prev);
    vec_t v;
    int size, off;
    logic [31:0] mask, val;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off  = int'(a[1:0]);
    v.mis = (off % size) != 0;
    off  = off - (off % size);
    mask = (size == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 32'h1;
    val  = (rdat >> (8 * off)) & mask;
    if (!f3[2] && size < 4 && val[8 * size - 1]) val = val | ~mask;
    v.we = we; v.f3 = f3; v.a = a; v.wd = wd; v.rdat = rdat; v.dly = dly;
    v.e_addr  = a & ~32'h3;
    v.e_strb  = we ? 4'(((1 << size) - 1) << off) : 4'h0;
    v.e_wdata = (size == 1) ? {24'h0, wd[7:0]} * 32'h0101_0101 :
                (size == 2) ? {16'h0, wd[15:0]} * 32'h0001_0001 : wd;
    v.e_rd    = we ? prev : val;
    return v;
  endfunction

  logic [31:0] model_rd;
  int          lat, err_cnt, req_cycles, stall_bad, extra_done;
  logic [31:0] g_addr, g_wdata;
  logic [3:0]  g_strb;
  logic        g_we;

  task automatic do_access(input vec_t v);
    int w;
    bit seen;
    mem_req = 1'b1; mem_we = v.we; funct3 = v.f3; addr = v.a; wdata = v.wd;
    lat = 0; err_cnt = 0; req_cycles = 0; stall_bad = 0; extra_done = 0;
    w = 0; seen = 1'b0;
    #1;
    if (stall !== 1'b1) stall_bad++;
    for (int cyc = 1; cyc <= 60 && lat == 0; cyc++) begin
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (bus_err) err_cnt++;
      if (done) begin
        lat = cyc;
        if (stall !== 1'b0) stall_bad++;
      end else begin
        if (stall !== 1'b1) stall_bad++;
        if (bus_req) begin
          req_cycles++;
          if (!seen) begin
            g_addr = bus_addr; g_we = bus_we; g_strb = bus_wstrb; g_wdata = bus_wdata;
            seen = 1'b1;
          end
          if (w == v.dly) begin
            bus_ack = 1'b1; bus_rdata = v.rdat;
          end
          w++;
        end
      end
    end
    @(posedge clk); #1;
    extra_done = int'(done);
    mem_req = 1'b0;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    do_access(v);
    if (TRAP && v.mis) begin
      chk({nm, ".trap_req"}, 32'(req_cycles), 32'd0);
      chk({nm, ".trap_err"}, 32'(err_cnt), 32'd1);
      chk({nm, ".trap_lat"}, 32'(lat), 32'd2);
      chk({nm, ".trap_rd"}, dram_rd, model_rd);
    end else begin
      chk({nm, ".addr"}, g_addr, v.e_addr);
      chk({nm, ".we"}, 32'(g_we), 32'(v.we));
      chk({nm, ".wstrb"}, 32'(g_strb), 32'(v.e_strb));
      if (v.we) chk({nm, ".wdata"}, g_wdata, v.e_wdata);
      chk({nm, ".rd"}, dram_rd, v.e_rd);
      chk({nm, ".lat"}, 32'(lat), 32'(3 + v.dly));
      chk({nm, ".err"}, 32'(err_cnt), 32'd0);
      model_rd = v.e_rd;
    end
    chk({nm, ".stall"}, 32'(stall_bad), 32'd0);
    chk({nm, ".pulse"}, 32'(extra_done), 32'd0);
  endtask

  vec_t tbl[15];
  vec_t rv;
  int   seen_done, seen_req;

  initial begin
    rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;
    model_rd = RESET_RD;

    tbl[0]  = mk(0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 2,  32'h100, 4'h0, 32'h0,        32'hDEADBEEF, 0);
    tbl[1]  = mk(0, 3'b000, 32'h103, 32'h0,        32'h80FF1234, 0,  32'h100, 4'h0, 32'h0,        32'hFFFFFF80, 0);
    tbl[2]  = mk(0, 3'b100, 32'h103, 32'h0,        32'h80FF1234, 1,  32'h100, 4'h0, 32'h0,        32'h00000080, 0);
    tbl[3]  = mk(0, 3'b001, 32'h102, 32'h0,        32'h80FF1234, 0,  32'h100, 4'h0, 32'h0,        32'hFFFF80FF, 0);
    tbl[4]  = mk(1, 3'b000, 32'h201, 32'h000000A5, 32'h55555555, 0,  32'h200, 4'h2, 32'hA5A5A5A5, 32'hFFFF80FF, 0);
    tbl[5]  = mk(1, 3'b001, 32'h202, 32'h1234ABCD, 32'h55555555, 1,  32'h200, 4'hC, 32'hABCDABCD, 32'hFFFF80FF, 0);
    tbl[6]  = mk(0, 3'b101, 32'h100, 32'h0,        32'h7FFF8001, 0,  32'h100, 4'h0, 32'h0,        32'h00008001, 0);
    tbl[7]  = mk(0, 3'b001, 32'h103, 32'h0,        32'h80017FFF, 0,  32'h100, 4'h0, 32'h0,        32'hFFFF8001, 1);
    tbl[8]  = mk(0, 3'b010, 32'h10E, 32'h0,        32'h11223344, 0,  32'h10C, 4'h0, 32'h0,        32'h11223344, 1);
    tbl[9]  = mk(0, 3'b011, 32'h104, 32'h0,        32'hA1B2C3D4, 0,  32'h104, 4'h0, 32'h0,        32'hA1B2C3D4, 0);
    tbl[10] = mk(1, 3'b010, 32'h10C, 32'hCAFEF00D, 32'h0,        0,  32'h10C, 4'hF, 32'hCAFEF00D, 32'hA1B2C3D4, 0);
    tbl[11] = mk(1, 3'b000, 32'h303, 32'h1234567F, 32'h0,        0,  32'h300, 4'h8, 32'h7F7F7F7F, 32'hA1B2C3D4, 0);
    tbl[12] = mk(1, 3'b111, 32'h300, 32'h01020304, 32'h0,        0,  32'h300, 4'hF, 32'h01020304, 32'hA1B2C3D4, 0);
    tbl[13] = mk(0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 0,  32'h100, 4'h0, 32'h0,        32'h0000007F, 0);
    tbl[14] = mk(0, 3'b010, 32'h200, 32'h0,        32'h13579BDF, 15, 32'h200, 4'h0, 32'h0,        32'h13579BDF, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset.req", 32'(bus_req), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.err", 32'(bus_err), 32'd0);
    chk("reset.rd", dram_rd, RESET_RD);
    chk("reset.addr", bus_addr, 32'h0);
    chk("reset.wstrb", 32'(bus_wstrb), 32'd0);
    chk("reset.stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) run_vec($sformatf("row%0d", i), tbl[i]);

    // Reset while the bus cycle is outstanding, then a stray ack.
    mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h40;
    @(posedge clk); #1;
    chk("rst_mid.req_before", 32'(bus_req), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid.req", 32'(bus_req), 32'd0);
    chk("rst_mid.rd", dram_rd, RESET_RD);
    chk("rst_mid.addr", bus_addr, 32'h0);
    chk("rst_mid.done", 32'(done), 32'd0);
    mem_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hBAD0BAD0;
    seen_done = 0; seen_req = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      bus_ack = 1'b0;
      seen_done += int'(done);
      seen_req  += int'(bus_req);
    end
    chk("rst_mid.late_done", 32'(seen_done), 32'd0);
    chk("rst_mid.late_req", 32'(seen_req), 32'd0);
    chk("rst_mid.late_rd", dram_rd, RESET_RD);
    model_rd = RESET_RD;

    for (int i = 0; i < 40; i++) begin
      rv = model(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 6)), model_rd);
      run_vec($sformatf("rnd%0d", i), rv);
    end

    run_vec("pre_tmo", model(1'b0, 3'b010, 32'h80, 32'h0, 32'hFFFF_FFFF, 0, model_rd));
    rv = model(1'b0, 3'b010, 32'h84, 32'h0, 32'h1234_5678, -1, model_rd);
    do_access(rv);
    chk("tmo.err", 32'(err_cnt), 32'd1);
    chk("tmo.req_cycles", 32'(req_cycles), 32'(TIMEOUT));
    chk("tmo.lat", 32'(lat), 32'(TIMEOUT + 2));
    chk("tmo.rd", dram_rd, RESET_RD);
    chk("tmo.pulse", 32'(extra_done), 32'd0);
    chk("tmo.idle_req", 32'(bus_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_dram_if.md
Name: lsu_dram_if

Overview:
Load/store unit sitting between the execute stage and data memory. It produces the `dram_rd` value that the write-back select consumes when `wd_sel` = 2'b11. It drives a word-aligned req/ack memory bus. Sub-word stores become byte strobes; sub-word loads are extracted and sign/zero-extended. The core is stalled until the access completes.

Parameters:
- TIMEOUT, 16, max cycles `bus_req` waits for `bus_ack` before aborting (≥2).
- RESET_RD, 32'h0000_0000, value of `dram_rd` after reset or abort.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_req  in  1  execute stage requests a memory access (level; held until done)
- mem_we  in  1  1 = store, 0 = load
- funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address from ALU
- wdata  in  32  store data (rs2)
- dram_rd  out  32  extended load result, registered
- done  out  1  one-cycle pulse when access finishes
- stall  out  1  hold PC/pipeline
- bus_err  out  1  one-cycle pulse on timeout (or misalign, see feature)
- bus_req  out  1  memory request, registered
- bus_we  out  1  memory write enable
- bus_addr  out  32  {addr[31:2],2'b00}
- bus_wstrb  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_rdata  in  32  memory read data, valid with bus_ack
- bus_ack  in  1  memory completion, one cycle

Behaviour:
- Reset (async, rst_n=0): state IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wstrb=0, bus_wdata=0, done=0, bus_err=0, dram_rd=RESET_RD; timeout counter=0. Reset mid-access drops bus_req immediately; a late bus_ack is ignored.
- FSM states: IDLE, WAIT, RESP.
- IDLE: mem_req=1 → latch mem_we, funct3, addr[1:0]; drive bus_* signals registered; go to WAIT. The cycle is N+0.
- WAIT: bus_req=1 and bus_* held stable.
  - bus_ack=1 → capture bus_rdata (loads only); bus_req=0; go to RESP.
  - Counter reaches TIMEOUT-1 without ack → bus_err pulse; dram_rd=RESET_RD; go to RESP.
- RESP: done=1 for exactly one cycle, then IDLE. The next mem_req is accepted in the following IDLE cycle.
- stall = mem_req & ~done. This is combinational, so the pipeline advances in the done cycle.
- Minimum latency: with ack in the first WAIT cycle, done asserts 3 cycles after mem_req.
- Store lanes:
  - SB: wstrb = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 0011 << {addr[1],1'b0}; wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111.
- Loads: bus_wstrb=0. The lane is selected by the latched addr[1:0].
  - LB/LH: sign-extend. LBU/LHU: zero-extend. LW: full word.
- Stores leave dram_rd unchanged.
- Unsupported funct3 (011, 110, 111): treated as LW / SW.
- Misaligned accesses (H with addr[0]=1, W with addr[1:0]≠0): the low address bits are forced to the natural alignment before lane selection.
- bus_ack in IDLE or RESP is ignored.

Optional Feature:
- MISALIGN_TRAP_EN defined: a misaligned access issues no bus cycle. IDLE goes directly to RESP with bus_err=1, done=1; dram_rd is unchanged.
- MISALIGN_TRAP_EN undefined: the forced-alignment behaviour above applies; bus_err is raised only on timeout.

Test Plan:
- LW, addr=0x100, memory returns 0xDEADBEEF, ack after 2 WAIT cycles → bus_addr=0x100, wstrb=0000, dram_rd=0xDEADBEEF, single done pulse, stall high until the done cycle.
- LB, addr=0x103, bus_rdata=0x80FF_1234 → dram_rd=0xFFFFFF80. LBU with the same inputs → 0x00000080. LH, addr=0x102 → 0xFFFF80FF.
- SB, addr=0x201, wdata=0x000000A5 → bus_wstrb=0010, bus_wdata=0xA5A5A5A5, bus_we=1, dram_rd unchanged.
- SH, addr=0x202, wdata=0x1234ABCD → wstrb=1100, bus_wdata=0xABCDABCD.
- Load with bus_ack never asserted, TIMEOUT=16 → bus_err pulse when the counter reaches 15, dram_rd=0, done pulse, back to IDLE.
- rst_n pulled low while in WAIT, then bus_ack arrives → all outputs 0 immediately, no done, ack ignored.
- With MISALIGN_TRAP_EN defined, LW at addr=0x102 → bus_req stays 0, bus_err=1 and done=1 in the same cycle.
